store_buffer: RTL
=================

# store_buffer

Four-entry write buffer between the MEM stage and data memory. Posted stores are absorbed in one cycle and drained to memory in the background. Loads that hit a buffered store are forwarded with zero latency; load misses go to memory ahead of pending drains. The MEM stage is stalled only when the buffer is full or a load miss is outstanding.

## Interface
Parameters:
- DEPTH, 4, number of store entries; must be a power of 2, ≥2
- AW, 32, byte address width
- DW, 32, data width (word-only accesses)

Ports:
- clk  in  1  rising-edge clock, the only clock in the block
- rst  in  1  asynchronous, active-low reset
- cpu_we  in  1  MEM-stage store request (MemWrite)
- cpu_re  in  1  MEM-stage load request (MemRead)
- cpu_addr  in  AW  byte address; bits [1:0] ignored
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data to MEM/WB; 0 when no load completes
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational
- mem_req  out  1  backing-memory request; held until mem_ack
- mem_we  out  1  1 = write (drain), 0 = read (load miss)
- mem_addr  out  AW  word-aligned address, stable while mem_req=1
- mem_wdata  out  DW  drain data, stable while mem_req=1
- mem_rdata  in  DW  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse

## Operation
- FIFO holds DEPTH entries of {addr[AW-1:2], data}, with head/tail pointers and a count in range 0..DEPTH.
- Store: if cpu_we=1 and count<DEPTH, enqueue at the clock edge and keep stall=0.
- Full store: if count==DEPTH, stall=1 and nothing is enqueued. This holds even if a drain ack arrives in the same cycle; the store enqueues on the next cycle.
- Load hit: cpu_re=1 and cpu_addr[AW-1:2] matches any valid entry. cpu_rdata is the data of the youngest matching entry in the same cycle, and stall=0. The head entry being drained still counts as valid until its ack.
- Load miss: stall=1 until the load completes (see FSM).
- cpu_we and cpu_re both high is illegal. The store wins, the load is ignored, and cpu_rdata=0.
- Memory-port FSM states: IDLE, DRAIN, LOAD, LDONE.
  - IDLE → LOAD if a load miss is present. Otherwise IDLE → DRAIN if count>0.
  - DRAIN: mem_req=1, mem_we=1, addr/data taken from the head. On mem_ack, pop the head and return to IDLE.
  - LOAD: mem_req=1, mem_we=0, mem_addr={cpu_addr[AW-1:2],2'b00}. On mem_ack, latch mem_rdata into ld_q and go to LDONE.
  - LDONE: cpu_rdata=ld_q, stall=0, for one cycle; then IDLE.
- A drain already in flight is never aborted. A load miss arriving during DRAIN waits for the ack, then goes IDLE → LOAD. Loads have priority over further drains.
- Stores enqueue normally during DRAIN/LOAD/LDONE when count<DEPTH.

## Timing
- Reset (rst=0, asynchronous): count=0, pointers=0, state=IDLE, ld_q=0. All outputs are 0: cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata. Buffered stores are discarded, and mem_req drops immediately even mid-transaction.
- Store latency: 1 cycle (accept → entry visible to hits in the next cycle).
- Load hit latency: 0 cycles (combinational).
- Load miss latency: stall spans the IDLE-detect cycle through the ack cycle; data is delivered in LDONE, 1 cycle after mem_ack.
- Minimum drain spacing: 2 cycles per store (DRAIN, IDLE).
- Pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0; pointers are never compared.
- Same-cycle enqueue and pop: count is unchanged and both pointers advance.

## Structure
- Package store_buffer_pkg holds the FSM state enum (IDLE, DRAIN, LOAD, LDONE) and the DEPTH default.
- Sub-module sb_fifo holds entry storage, pointers, count, and the associative youngest-match search. It outputs hit and hit_data.
- The top level holds the FSM, ld_q, the stall logic, and the memory-port muxing.

## Test plan
- Reset with entries pending and mem_req=1, then drive rst=0 → mem_req=0 the same cycle, count=0, stall=0.
- Store 0x10←0xAAAA, then load 0x10 in the next cycle, before the drain ack → cpu_rdata=0xAAAA, stall=0, no read request issued.
- Store 0x20←1, then 0x20←2, then load 0x22 → cpu_rdata=2 (youngest match, low bits ignored). Memory ends at 0x20=2 after both drains complete in order.
- 5 stores back-to-back with mem_ack held low → first 4 accepted, stall=1 on the 5th. One ack → 5th accepted the following cycle.
- Load 0x40 miss with memory returning 0x1234 after a 3-cycle ack delay → stall=1 until ack, cpu_rdata=0x1234 in LDONE, then stall=0.
- Load miss during DRAIN → write completes first, then the read is issued. Remaining stores drain only after LDONE.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: memory-port FSM states and default depth.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        LDONE = 2'd3
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Store entry FIFO with an associative lookup that returns the youngest
// valid entry whose word address matches.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AW-3:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic [AW-3:0]            lookup_addr,
    output logic                     hit,
    output logic [DW-1:0]            hit_data,
    output logic [AW-3:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] idx;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload needs no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-store write buffer between the MEM stage and data memory.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no memory transaction; pick a load miss first, else a drain
// DRAIN | writing the head entry to memory, waiting for mem_ack
// LOAD  | reading the missed load address, waiting for mem_ack
// LDONE | returning the latched read data to the MEM stage for one cycle
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t     state_q, state_d;
    logic [DW-1:0] ld_q;
    logic [CW-1:0] count;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [AW-3:0] head_addr;
    logic [DW-1:0] head_data;
    logic          full, store_ok, load_req, load_miss, pop;
    logic          unused_addr_bits;

    // Byte offset is irrelevant for word-only accesses.
    assign unused_addr_bits = ^cpu_addr[1:0];

    // A simultaneous store and load is treated as a store only.
    assign full      = (count == CW'(DEPTH));
    assign store_ok  = cpu_we & ~full;
    assign load_req  = cpu_re & ~cpu_we;
    assign load_miss = load_req & ~hit;
    assign pop       = (state_q == DRAIN) & mem_ack;

    sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (store_ok),
        .push_addr   (cpu_addr[AW-1:2]),
        .push_data   (cpu_wdata),
        .pop         (pop),
        .lookup_addr (cpu_addr[AW-1:2]),
        .hit         (hit),
        .hit_data    (hit_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count)
    );

    // State register and load-return latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == LOAD) && mem_ack) ld_q <= mem_rdata;
        end
    end

    // Next state, memory-port muxing, load return data and stall.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        stall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_miss)          state_d = LOAD;
                else if (count != '0)   state_d = DRAIN;
            end
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {head_addr, 2'b00};
                mem_wdata = head_data;
                if (mem_ack) state_d = IDLE;
            end
            LOAD: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[AW-1:2], 2'b00};
                if (mem_ack) state_d = LDONE;
            end
            LDONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The missed load is still presented in LDONE and completes there.
        if (state_q == LDONE) begin
            if (load_req) cpu_rdata = ld_q;
        end else begin
            if (load_req && hit) cpu_rdata = hit_data;
            if (load_miss)       stall     = 1'b1;
        end
        // Full check uses the current count, so a same-cycle drain ack does not help.
        if (cpu_we && full) stall = 1'b1;

        if (!rst) begin
            stall     = 1'b0;
            cpu_rdata = '0;
        end
    end

endmodule
